// File: rtl/vga_mode_controller_if.sv
// Controller <-> timing generator / host bundle; the master side is the mode controller.
// Generator counts and next strobes flow in, enables and per-mode config flow out.
interface vga_mode_controller_if;
   logic [1:0]  mode_sel;
   logic        mode_req;
   logic [15:0] h_pos;
   logic [15:0] v_pos;
   logic        h_next;
   logic        v_next;
   logic        h_enable;
   logic        v_enable;
   logic [15:0] h_resolution;
   logic [15:0] h_front_porch;
   logic [15:0] h_sync;
   logic [15:0] h_back_porch;
   logic [15:0] v_resolution;
   logic [15:0] v_front_porch;
   logic [15:0] v_sync;
   logic [15:0] v_back_porch;
   logic        h_negative;
   logic        v_negative;
   logic        video_valid;
   logic        display_enable;
   logic        frame_start;
   logic        mode_ack;
   logic        busy;
   logic [1:0]  cur_mode;

   modport master (
      input  mode_sel, mode_req, h_pos, v_pos, h_next, v_next,
      output h_enable, v_enable,
      output h_resolution, h_front_porch, h_sync, h_back_porch,
      output v_resolution, v_front_porch, v_sync, v_back_porch,
      output h_negative, v_negative, video_valid, display_enable,
      output frame_start, mode_ack, busy, cur_mode
   );

   modport slave (
      output mode_sel, mode_req, h_pos, v_pos, h_next, v_next,
      input  h_enable, v_enable,
      input  h_resolution, h_front_porch, h_sync, h_back_porch,
      input  v_resolution, v_front_porch, v_sync, v_back_porch,
      input  h_negative, v_negative, video_valid, display_enable,
      input  frame_start, mode_ack, busy, cur_mode
   );
endinterface

// File: rtl/vga_mode_controller.sv
// Four-entry video mode table driving a horizontal/vertical vga_timing pair; mode requests
// are latched any time and applied at the next frame boundary (timing at A, resolution at F).
module vga_mode_controller #(
   parameter logic [63:0] H_RES      = {16'd16, 16'd1024, 16'd800, 16'd640},
   parameter logic [63:0] H_FP       = {16'd2,  16'd24,   16'd40,  16'd16},
   parameter logic [63:0] H_SYNC     = {16'd3,  16'd136,  16'd128, 16'd96},
   parameter logic [63:0] H_BP       = {16'd4,  16'd160,  16'd88,  16'd48},
   parameter logic [63:0] V_RES      = {16'd8,  16'd768,  16'd600, 16'd480},
   parameter logic [63:0] V_FP       = {16'd1,  16'd3,    16'd1,   16'd10},
   parameter logic [63:0] V_SYNC     = {16'd2,  16'd6,    16'd4,   16'd2},
   parameter logic [63:0] V_BP       = {16'd1,  16'd29,   16'd23,  16'd33},
   parameter logic [3:0]  H_NEG      = 4'b0101,
   parameter logic [3:0]  V_NEG      = 4'b0101,
   parameter logic [1:0]  RESET_MODE = 2'd0
) (
   input  logic                   clock,
   input  logic                   reset,
   vga_mode_controller_if.master  bus
);

   typedef enum logic [1:0] {
      ST_STARTUP,
      ST_RUN,
      ST_COMMIT
   } state_t;

   typedef struct packed {
      logic [15:0] h_fp;
      logic [15:0] h_sync;
      logic [15:0] h_bp;
      logic [15:0] v_fp;
      logic [15:0] v_sync;
      logic [15:0] v_bp;
      logic        h_neg;
      logic        v_neg;
   } timing_t;

   typedef struct packed {
      logic [15:0] h_res;
      logic [15:0] v_res;
      logic [1:0]  mode;
   } res_t;

   function automatic timing_t timing_of(input logic [1:0] m);
      timing_t t;
      t.h_fp   = H_FP[{m, 4'b0000} +: 16];
      t.h_sync = H_SYNC[{m, 4'b0000} +: 16];
      t.h_bp   = H_BP[{m, 4'b0000} +: 16];
      t.v_fp   = V_FP[{m, 4'b0000} +: 16];
      t.v_sync = V_SYNC[{m, 4'b0000} +: 16];
      t.v_bp   = V_BP[{m, 4'b0000} +: 16];
      t.h_neg  = H_NEG[m];
      t.v_neg  = V_NEG[m];
      return t;
   endfunction

   function automatic res_t res_of(input logic [1:0] m);
      res_t r;
      r.h_res = H_RES[{m, 4'b0000} +: 16];
      r.v_res = V_RES[{m, 4'b0000} +: 16];
      r.mode  = m;
      return r;
   endfunction

   state_t      state_q, state_d;
   timing_t     tim_q, tim_d;
   res_t        res_q, res_d;
   logic        pend_q, pend_d;
   logic [1:0]  pend_mode_q, pend_mode_d;
   logic [1:0]  arm_mode_q, arm_mode_d;
   logic        video_valid_q, video_valid_d;
   logic        frame_start_q, frame_start_d;
   logic        mode_ack_q, mode_ack_d;
   logic        frame_end;
   logic        arm_point;

   assign bus.h_enable = ~reset;
   assign bus.v_enable = bus.h_enable & bus.h_next;

   assign frame_end = bus.h_enable & bus.h_next & bus.v_next;
   // One pixel before the last active pixel of the frame, so F follows on the next edge.
   assign arm_point = (bus.h_pos == res_q.h_res - 16'd2) &
                      (bus.v_pos == res_q.v_res - 16'd1);

   always_comb begin
      state_d       = state_q;
      tim_d         = tim_q;
      res_d         = res_q;
      pend_d        = pend_q;
      pend_mode_d   = pend_mode_q;
      arm_mode_d    = arm_mode_q;
      video_valid_d = video_valid_q;
      frame_start_d = frame_end & (state_q != ST_STARTUP);
      mode_ack_d    = (state_q == ST_COMMIT);

      if (bus.mode_req) begin
         pend_d      = 1'b1;
         pend_mode_d = bus.mode_sel;
      end

      case (state_q)
         ST_STARTUP: begin
            // Generators are not aligned yet, so a switch can land immediately.
            if (bus.mode_req) begin
               tim_d  = timing_of(bus.mode_sel);
               res_d  = res_of(bus.mode_sel);
               pend_d = 1'b0;
            end
            if (frame_end) begin
               state_d       = ST_RUN;
               video_valid_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (pend_q && arm_point) begin
               tim_d      = timing_of(pend_mode_q);
               arm_mode_d = pend_mode_q;
               pend_d     = bus.mode_req;
               state_d    = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            res_d   = res_of(arm_mode_q);
            state_d = ST_RUN;
         end
         default: state_d = ST_STARTUP;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_STARTUP;
         tim_q         <= timing_of(RESET_MODE);
         res_q         <= res_of(RESET_MODE);
         pend_q        <= 1'b0;
         pend_mode_q   <= RESET_MODE;
         arm_mode_q    <= RESET_MODE;
         video_valid_q <= 1'b0;
         frame_start_q <= 1'b0;
         mode_ack_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         tim_q         <= tim_d;
         res_q         <= res_d;
         pend_q        <= pend_d;
         pend_mode_q   <= pend_mode_d;
         arm_mode_q    <= arm_mode_d;
         video_valid_q <= video_valid_d;
         frame_start_q <= frame_start_d;
         mode_ack_q    <= mode_ack_d;
      end
   end

   assign bus.h_resolution   = res_q.h_res;
   assign bus.v_resolution   = res_q.v_res;
   assign bus.cur_mode       = res_q.mode;
   assign bus.h_front_porch  = tim_q.h_fp;
   assign bus.h_sync         = tim_q.h_sync;
   assign bus.h_back_porch   = tim_q.h_bp;
   assign bus.v_front_porch  = tim_q.v_fp;
   assign bus.v_sync         = tim_q.v_sync;
   assign bus.v_back_porch   = tim_q.v_bp;
   assign bus.h_negative     = tim_q.h_neg;
   assign bus.v_negative     = tim_q.v_neg;
   assign bus.video_valid    = video_valid_q;
   assign bus.frame_start    = frame_start_q;
   assign bus.mode_ack       = mode_ack_q;
   assign bus.busy           = pend_q | (state_q == ST_COMMIT);
   assign bus.display_enable = video_valid_q &
                               (bus.h_pos < res_q.h_res) &
                               (bus.v_pos < res_q.v_res);

endmodule
